// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Single-port RAM arbiter between the instruction-fetch requester and the
//   data (LDR/STR) requester. One access is in flight at a time. The FSM walks
//   IDLE -> ISSUE -> (WAIT ->) DONE -> IDLE. The winner gets its read data and a
//   one-cycle done pulse.
//
//   Optional build macro: MEM_ARB_FIXED_PRIO_EN
//     defined   : on a tie the data requester always wins
//     undefined : round-robin on ties; fetch wins the first tie after reset
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   if_req/if_addr        fetch request (level) and address
//   if_done/if_rdata      fetch completion pulse and held fetched word
//   d_req/d_we/d_addr/d_wdata  data request (level), store flag, address, data
//   d_done/d_rdata        data completion pulse and held load word
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  RAM control and data pins
//   busy                  high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 8,
    parameter int RAM_LAT = 1     // 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_done,
    output logic [DWIDTH-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_done,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic              busy
);

    localparam int CW = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

    // Transaction latched in IDLE; nothing on the request ports matters
    // again until the FSM is back in IDLE.
    typedef struct packed {
        owner_t              owner;
        logic                we;
        logic [AWIDTH-1:0]   addr;
        logic [DWIDTH-1:0]   wdata;
    } txn_t;

    state_t              state_q, state_d;
    txn_t                txn_q, txn_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DWIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DWIDTH-1:0]   d_rdata_q, d_rdata_d;
    owner_t              grant;
`ifndef MEM_ARB_FIXED_PRIO_EN
    owner_t              last_owner_q, last_owner_d;
`endif

    // Winner among the current requesters; only consumed in IDLE.
    always_comb begin
        grant = OWN_IF;
        if (if_req && d_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            grant = OWN_D;
`else
            grant = (last_owner_q == OWN_D) ? OWN_IF : OWN_D;
`endif
        end else if (d_req) begin
            grant = OWN_D;
        end
    end

    always_comb begin
        state_d    = state_q;
        txn_d      = txn_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    txn_d.owner = grant;
                    txn_d.we    = (grant == OWN_D) && d_we;
                    txn_d.addr  = (grant == OWN_D) ? d_addr : if_addr;
                    txn_d.wdata = (grant == OWN_D) ? d_wdata : '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_owner_d = grant;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (txn_q.we) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CW'(RAM_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                // Count of 1 marks the cycle the RAM word is valid.
                if (cnt_q == CW'(1)) begin
                    if (txn_q.owner == OWN_D) d_rdata_d  = ram_rdata;
                    else                      if_rdata_d = ram_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            txn_q        <= '0;
            cnt_q        <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_owner_q <= OWN_D;
`endif
        end else begin
            state_q      <= state_d;
            txn_q        <= txn_d;
            cnt_q        <= cnt_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Outputs decode registered state only, so reset clears them at once.
    assign ram_en    = (state_q == ISSUE);
    assign ram_we    = (state_q == ISSUE) && txn_q.we;
    assign ram_addr  = txn_q.addr;
    assign ram_wdata = txn_q.wdata;
    assign busy      = (state_q != IDLE);
    assign if_done   = (state_q == DONE) && (txn_q.owner == OWN_IF);
    assign d_done    = (state_q == DONE) && (txn_q.owner == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Two arbiters share the requester inputs: u_dut (RAM_LAT=1) and u_dut4
//   (RAM_LAT=4), each with its own RAM model. Directed scenarios plus a
//   randomized transaction stream checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0]  if_addr = '0, d_addr = '0;
    logic [15:0] d_wdata = '0;

    logic        if_done, d_done, ram_en, ram_we, busy;
    logic [15:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
    logic [7:0]  ram_addr;

    logic        if_done4, d_done4, ram_en4, ram_we4, busy4;
    logic [15:0] if_rdata4, d_rdata4, ram_wdata4, ram_rdata4;
    logic [7:0]  ram_addr4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ref_mem [256];

    always #5 clk = ~clk;

    mem_arbiter #(.DWIDTH(16), .AWIDTH(8), .RAM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_arbiter #(.DWIDTH(16), .AWIDTH(8), .RAM_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done4), .if_rdata(if_rdata4),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done4), .d_rdata(d_rdata4),
        .ram_en(ram_en4), .ram_we(ram_we4), .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
        .ram_rdata(ram_rdata4), .busy(busy4)
    );

    function automatic logic [15:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 16'h1234;
        return {~a, a} ^ 16'h0F0F;
    endfunction

    // RAM models: read word appears RAM_LAT cycles after the ram_en cycle;
    // any other cycle shows a sentinel so a mistimed capture is visible.
    logic [15:0] mem1 [256];
    bit          wr1  [256];
    logic [15:0] rpipe1 = 16'hDEAD;
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            mem1[ram_addr] <= ram_wdata;
            wr1[ram_addr]  <= 1'b1;
        end
        rpipe1 <= (ram_en && !ram_we) ? (wr1[ram_addr] ? mem1[ram_addr] : init_val(ram_addr))
                                      : 16'hDEAD;
    end
    assign ram_rdata = rpipe1;

    logic [15:0] mem4 [256];
    bit          wr4  [256];
    logic [15:0] rpipe4 [4] = '{16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD};
    always @(posedge clk) begin
        if (ram_en4 && ram_we4) begin
            mem4[ram_addr4] <= ram_wdata4;
            wr4[ram_addr4]  <= 1'b1;
        end
        rpipe4[0] <= (ram_en4 && !ram_we4) ? (wr4[ram_addr4] ? mem4[ram_addr4] : init_val(ram_addr4))
                                           : 16'hDEAD;
        for (int i = 1; i < 4; i++) rpipe4[i] <= rpipe4[i-1];
    end
    assign ram_rdata4 = rpipe4[3];

    // Reset both DUTs and leave the bench at a negedge with the FSMs in IDLE.
    task automatic do_reset();
        if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Counts negedges until a done pulse from u_dut; cyc = budget+1 on timeout.
    task automatic wait_done(input int budget, output int cyc, output bit fi, output bit fd);
        fi = 0; fd = 0;
        for (cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (if_done || d_done) begin
                fi = if_done; fd = d_done;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (ram_en !== 1'b0)  begin n_fail++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
        do_reset();
        n_checks++; if (ram_we !== 1'b0)  begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        n_checks++; if (if_done !== 1'b0 || d_done !== 1'b0)
            begin n_fail++; $display("FAIL reset_done: got %b%b want 00", if_done, d_done); end
        n_checks++; if (ram_addr !== 8'h0)   begin n_fail++; $display("FAIL reset_ram_addr: got %h want 00", ram_addr); end
        n_checks++; if (ram_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_ram_wdata: got %h want 0000", ram_wdata); end
        n_checks++; if (if_rdata !== 16'h0 || d_rdata !== 16'h0)
            begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", if_rdata, d_rdata); end
        n_checks++; if (busy4 !== 1'b0 || ram_en4 !== 1'b0)
            begin n_fail++; $display("FAIL reset_dut4: got busy %b en %b want 0 0", busy4, ram_en4); end
    endtask

    task automatic test_fetch();
        do_reset();
        if_req = 1; if_addr = 8'h10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++; if (ram_en !== (k == 1))
                begin n_fail++; $display("FAIL fetch_ram_en k=%0d: got %b want %b", k, ram_en, k == 1); end
            n_checks++; if (if_done !== (k == 3))
                begin n_fail++; $display("FAIL fetch_if_done k=%0d: got %b want %b", k, if_done, k == 3); end
            n_checks++; if (d_done !== 1'b0)
                begin n_fail++; $display("FAIL fetch_d_done k=%0d: got %b want 0", k, d_done); end
            if (k == 1) begin
                n_checks++; if (ram_addr !== 8'h10 || ram_we !== 1'b0)
                    begin n_fail++; $display("FAIL fetch_ram_addr: got %h we %b want 10 0", ram_addr, ram_we); end
            end
            if (k >= 3) begin
                n_checks++; if (if_rdata !== 16'h1234)
                    begin n_fail++; $display("FAIL fetch_if_rdata k=%0d: got %h want 1234", k, if_rdata); end
            end
            if (k == 3) if_req = 0;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_store_load();
        int cyc; bit fi, fd;
        do_reset();
        if_req = 1; if_addr = 8'h10;
        wait_done(10, cyc, fi, fd);
        if_req = 0;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 16'hBEEF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++; if (ram_we !== (k == 1))
                begin n_fail++; $display("FAIL store_ram_we k=%0d: got %b want %b", k, ram_we, k == 1); end
            n_checks++; if (d_done !== (k == 2))
                begin n_fail++; $display("FAIL store_d_done k=%0d: got %b want %b", k, d_done, k == 2); end
            if (k == 1) begin
                n_checks++; if (ram_addr !== 8'h20 || ram_wdata !== 16'hBEEF)
                    begin n_fail++; $display("FAIL store_ram_pins: got %h/%h want 20/beef", ram_addr, ram_wdata); end
            end
            if (k == 2) begin
                n_checks++; if (d_rdata !== 16'h0)
                    begin n_fail++; $display("FAIL store_d_rdata: got %h want 0000", d_rdata); end
                d_req = 0;
                ref_mem[8'h20] = 16'hBEEF;
            end
        end
        d_req = 1; d_we = 0; d_addr = 8'h20; d_wdata = 16'h0;
        wait_done(10, cyc, fi, fd);
        d_req = 0;
        n_checks++; if (cyc !== 3 || fd !== 1'b1 || fi !== 1'b0)
            begin n_fail++; $display("FAIL load_done: got cyc %0d if %b d %b want 3 0 1", cyc, fi, fd); end
        n_checks++; if (d_rdata !== ref_mem[8'h20])
            begin n_fail++; $display("FAIL load_d_rdata: got %h want %h", d_rdata, ref_mem[8'h20]); end
        n_checks++; if (if_rdata !== 16'h1234)
            begin n_fail++; $display("FAIL load_if_rdata_kept: got %h want 1234", if_rdata); end
    endtask

    task automatic test_tie();
        int cyc; bit fi, fd, want_d;
        do_reset();
        if_req = 1; if_addr = 8'h40; d_req = 1; d_we = 0; d_addr = 8'h30;
        for (int i = 0; i < 4; i++) begin
            want_d = FIXED ? 1'b1 : (i % 2 == 1);
            wait_done(12, cyc, fi, fd);
            n_checks++; if (cyc !== ((i == 0) ? 3 : 4))
                begin n_fail++; $display("FAIL tie_cycles i=%0d: got %0d want %0d", i, cyc, (i == 0) ? 3 : 4); end
            n_checks++; if (fi !== !want_d || fd !== want_d)
                begin n_fail++; $display("FAIL tie_owner i=%0d: got if %b d %b want if %b d %b", i, fi, fd, !want_d, want_d); end
        end
        n_checks++; if (if_rdata !== (FIXED ? 16'h0 : ref_mem[8'h40]) || d_rdata !== ref_mem[8'h30])
            begin n_fail++; $display("FAIL tie_rdata: got %h/%h", if_rdata, d_rdata); end
        if_req = 0; d_req = 0;
    endtask

    task automatic test_lat4();
        do_reset();
        n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL lat4_busy_t0: got %b want 0", busy4); end
        d_req = 1; d_we = 0; d_addr = 8'h55;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_checks++; if (busy4 !== (k <= 6))
                begin n_fail++; $display("FAIL lat4_busy k=%0d: got %b want %b", k, busy4, k <= 6); end
            n_checks++; if (d_done4 !== (k == 6))
                begin n_fail++; $display("FAIL lat4_d_done k=%0d: got %b want %b", k, d_done4, k == 6); end
            n_checks++; if (ram_addr4 !== 8'h55)
                begin n_fail++; $display("FAIL lat4_ram_addr k=%0d: got %h want 55", k, ram_addr4); end
            if (k == 3) d_addr = 8'hAA;
            if (k == 6) begin
                n_checks++; if (d_rdata4 !== ref_mem[8'h55])
                    begin n_fail++; $display("FAIL lat4_d_rdata: got %h want %h", d_rdata4, ref_mem[8'h55]); end
                d_req = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit fi, fd;
        do_reset();
        if_req = 1; if_addr = 8'h10;
        wait_done(10, cyc, fi, fd);
        repeat (3) @(negedge clk);   // held request: IDLE, ISSUE, WAIT of a second fetch
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
        #2 rst = 1;
        #1;
        n_checks++; if (busy !== 1'b0 || ram_en !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_immediate: got busy %b en %b want 0 0", busy, ram_en); end
        n_checks++; if (if_done !== 1'b0 || d_done !== 1'b0 || if_rdata !== 16'h0)
            begin n_fail++; $display("FAIL rstmid_outputs: got %b%b %h want 00 0000", if_done, d_done, if_rdata); end
        if_req = 0;
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (if_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b0)
                begin n_fail++; $display("FAIL rstmid_no_done k=%0d: got %b%b busy %b", k, if_done, d_done, busy); end
        end
        if_req = 1; if_addr = 8'h10; d_req = 1; d_we = 0; d_addr = 8'h31;
        wait_done(10, cyc, fi, fd);
        if_req = 0; d_req = 0;
        n_checks++; if (cyc !== 3 || fi !== !FIXED || fd !== FIXED)
            begin n_fail++; $display("FAIL rstmid_tie: got cyc %0d if %b d %b want 3 %b %b", cyc, fi, fd, !FIXED, FIXED); end
    endtask

    task automatic test_drop();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 8'h33;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) d_req = 0;
            n_checks++; if (d_done !== (k == 3))
                begin n_fail++; $display("FAIL drop_d_done k=%0d: got %b want %b", k, d_done, k == 3); end
            n_checks++; if (busy !== (k <= 3))
                begin n_fail++; $display("FAIL drop_busy k=%0d: got %b want %b", k, busy, k <= 3); end
        end
        n_checks++; if (d_rdata !== ref_mem[8'h33])
            begin n_fail++; $display("FAIL drop_d_rdata: got %h want %h", d_rdata, ref_mem[8'h33]); end
    endtask

    // Transaction-level model: each requester is pending or not; a grant goes
    // to the sole requester or by the tie rule, then loads update the
    // winner's word and stores update the model memory.
    task automatic test_random();
        bit pi, pd, wd, gd, last_d, fi, fd;
        logic [7:0] ai, ad;
        logic [15:0] dd, e_if, e_d;
        int cyc, ecyc;
        do_reset();
        pi = 0; pd = 0; wd = 0; ai = '0; ad = '0; dd = '0;
        last_d = 1; e_if = '0; e_d = '0;
        for (int n = 0; n < 80; n++) begin
            if (!pi && !pd) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    n_checks++; if (busy !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0)
                        begin n_fail++; $display("FAIL rand_idle n=%0d: got busy %b done %b%b", n, busy, if_done, d_done); end
                end
            end
            if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; ai = 8'($urandom_range(0, 16)); end
            if (!pd && $urandom_range(0, 1) == 1) begin
                pd = 1; ad = 8'($urandom_range(0, 15)); wd = 1'($urandom_range(0, 1)); dd = 16'($urandom);
            end
            if (!pi && !pd) begin pi = 1; ai = 8'($urandom_range(0, 16)); end
            if_req = pi; if_addr = ai; d_req = pd; d_addr = ad; d_we = wd; d_wdata = dd;

            gd = (pi && pd) ? (FIXED ? 1'b1 : !last_d) : pd;
            last_d = gd;
            ecyc = (gd && wd) ? 2 : 3;
            if (!gd)          e_if = ref_mem[ai];
            else if (!wd)     e_d  = ref_mem[ad];
            else              ref_mem[ad] = dd;

            wait_done(12, cyc, fi, fd);
            n_checks++; if (cyc !== ecyc)
                begin n_fail++; $display("FAIL rand_cycles n=%0d: got %0d want %0d", n, cyc, ecyc); end
            n_checks++; if (fi !== !gd || fd !== gd)
                begin n_fail++; $display("FAIL rand_owner n=%0d: got if %b d %b want if %b d %b", n, fi, fd, !gd, gd); end
            n_checks++; if (if_rdata !== e_if)
                begin n_fail++; $display("FAIL rand_if_rdata n=%0d: got %h want %h", n, if_rdata, e_if); end
            n_checks++; if (d_rdata !== e_d)
                begin n_fail++; $display("FAIL rand_d_rdata n=%0d: got %h want %h", n, d_rdata, e_d); end
            if (gd) begin pd = 0; d_req = 0; end
            else    begin pi = 0; if_req = 0; end
            @(negedge clk);
        end
        if_req = 0; d_req = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        test_reset();
        test_fetch();
        test_store_load();
        test_tie();
        test_lat4();
        test_reset_mid();
        test_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
